// File: rtl/button_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
// Contents:
//   clog2_min1    - counter width for a terminal count, never below one bit
//   hold_state_t  - per-channel long-press state
//   Def*Ticks     - default tick counts for the top-level parameters
package button_pkg;

    localparam int unsigned DefDebounceTicks = 20;
    localparam int unsigned DefHoldTicks     = 1000;
    localparam int unsigned DefRepeatTicks   = 200;

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StRepeating
    } hold_state_t;

    // Width needed to hold values 0..value; a zero-valued parameter still gets a 1-bit counter.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = $clog2(value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, tick-gated debounce, press/release
// pulses, and a long-press FSM with optional auto-repeat.
// Ports:
//   i_clk, i_rst_n     - clock, synchronous active-low reset
//   i_tick_en          - sample enable for all tick counters
//   i_btn_raw          - asynchronous raw button
//   o_btn_level        - debounced level, 1 = pressed
//   o_press_pulse      - one-clk pulse on debounced press
//   o_release_pulse    - one-clk pulse on debounced release
//   o_hold_pulse       - one-clk pulse once a press has lasted HOLD_TICKS
//   o_repeat_pulse     - one-clk pulse every REPEAT_TICKS after the hold pulse
module button_channel
    import button_pkg::*;
#(
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks,
    parameter int unsigned HOLD_TICKS     = DefHoldTicks,
    parameter int unsigned REPEAT_TICKS   = DefRepeatTicks
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick_en,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_hold_pulse,
    output logic o_repeat_pulse
);

    localparam int unsigned DbW   = clog2_min1(DEBOUNCE_TICKS);
    localparam int unsigned HoldW = clog2_min1(HOLD_TICKS);
    localparam int unsigned RptW  = clog2_min1(REPEAT_TICKS);
    localparam int unsigned CntW  = (HoldW > RptW) ? HoldW : RptW;

    localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_TICKS - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_TICKS - 1);
    localparam logic [CntW-1:0] RptLast  = CntW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam logic            Released = logic'(ACTIVE_LOW);

    logic            r_sync1, r_sync2;
    logic            r_level, r_press, r_release, r_hold, r_repeat;
    logic [DbW-1:0]  r_db_cnt;
    logic [DbW-1:0]  w_db_cnt_d;
    logic [CntW-1:0] r_hold_cnt;
    logic [CntW-1:0] w_hold_cnt_d;
    hold_state_t     r_state, w_state_d;
    logic            w_pressed_s, w_mismatch, w_flip, w_rise, w_fall;
    logic            w_hold_fire, w_repeat_fire;

    assign w_pressed_s = r_sync2 ^ ACTIVE_LOW;
    assign w_mismatch  = (w_pressed_s != r_level);
    assign w_flip      = w_mismatch & i_tick_en & (r_db_cnt == DbLast);
    assign w_rise      = w_flip & w_pressed_s;
    assign w_fall      = w_flip & ~w_pressed_s;

    always_comb begin
        w_db_cnt_d = r_db_cnt;
        if (!w_mismatch) begin
            w_db_cnt_d = '0;
        end else if (i_tick_en) begin
            w_db_cnt_d = w_flip ? '0 : r_db_cnt + DbW'(1);
        end
    end

    // A release always takes priority over a hold/repeat terminal count on the same edge.
    always_comb begin
        w_state_d     = r_state;
        w_hold_cnt_d  = r_hold_cnt;
        w_hold_fire   = 1'b0;
        w_repeat_fire = 1'b0;
        if (w_fall) begin
            w_state_d    = StIdle;
            w_hold_cnt_d = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        w_state_d    = StPressed;
                        w_hold_cnt_d = '0;
                    end
                end
                StPressed: begin
                    if (i_tick_en) begin
                        if (r_hold_cnt == HoldLast) begin
                            w_hold_fire  = 1'b1;
                            w_state_d    = StRepeating;
                            w_hold_cnt_d = '0;
                        end else begin
                            w_hold_cnt_d = r_hold_cnt + CntW'(1);
                        end
                    end
                end
                StRepeating: begin
                    if ((REPEAT_TICKS > 0) && i_tick_en) begin
                        if (r_hold_cnt == RptLast) begin
                            w_repeat_fire = 1'b1;
                            w_hold_cnt_d  = '0;
                        end else begin
                            w_hold_cnt_d = r_hold_cnt + CntW'(1);
                        end
                    end
                end
                default: begin
                    w_state_d    = StIdle;
                    w_hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1    <= Released;
            r_sync2    <= Released;
            r_level    <= 1'b0;
            r_db_cnt   <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
            r_repeat   <= 1'b0;
            r_state    <= StIdle;
            r_hold_cnt <= '0;
        end else begin
            r_sync1    <= i_btn_raw;
            r_sync2    <= r_sync1;
            r_level    <= w_flip ? w_pressed_s : r_level;
            r_db_cnt   <= w_db_cnt_d;
            r_press    <= w_rise;
            r_release  <= w_fall;
            r_hold     <= w_hold_fire;
            r_repeat   <= w_repeat_fire;
            r_state    <= w_state_d;
            r_hold_cnt <= w_hold_cnt_d;
        end
    end

    assign o_btn_level     = r_level;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_hold_pulse    = r_hold;
    assign o_repeat_pulse  = r_repeat;

endmodule

// File: rtl/button_conditioner_multi.sv
// N_CH independent button conditioners (synchronise, debounce, edge and
// long-press detection) sharing one clock, reset and tick strobe.
// Ports:
//   i_clk, i_rst_n     - clock, synchronous active-low reset
//   i_tick_en          - sample enable (e.g. 1 kHz strobe), tie high for per-clock counting
//   i_btn_raw          - raw asynchronous buttons, one bit per channel
//   o_btn_level        - debounced levels, 1 = pressed
//   o_press_pulse      - per-channel one-clk press pulses
//   o_release_pulse    - per-channel one-clk release pulses
//   o_hold_pulse       - per-channel one-clk long-press pulses
//   o_repeat_pulse     - per-channel one-clk auto-repeat pulses
module button_conditioner_multi
    import button_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks,
    parameter int unsigned HOLD_TICKS     = DefHoldTicks,
    parameter int unsigned REPEAT_TICKS   = DefRepeatTicks
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick_en,
    input  logic [N_CH-1:0] i_btn_raw,
    output logic [N_CH-1:0] o_btn_level,
    output logic [N_CH-1:0] o_press_pulse,
    output logic [N_CH-1:0] o_release_pulse,
    output logic [N_CH-1:0] o_hold_pulse,
    output logic [N_CH-1:0] o_repeat_pulse
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .HOLD_TICKS     (HOLD_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_channel (
            .i_clk           (i_clk),
            .i_rst_n         (i_rst_n),
            .i_tick_en       (i_tick_en),
            .i_btn_raw       (i_btn_raw[g]),
            .o_btn_level     (o_btn_level[g]),
            .o_press_pulse   (o_press_pulse[g]),
            .o_release_pulse (o_release_pulse[g]),
            .o_hold_pulse    (o_hold_pulse[g]),
            .o_repeat_pulse  (o_repeat_pulse[g])
        );
    end

endmodule
